enum_stepper: RTL and testbench
===============================

Name: enum_stepper

Overview:
- Synthesizable cursor over a fixed, sparse SystemVerilog enumeration; hardware equivalent of the enum `first`/`last`/`next(N)`/`prev(N)` methods plus a value lookup.
- Accepts step commands over a valid/ready interface.
- Emits the resulting member (value, ordinal index, wrap/error flags) on a valid/ready output stream.
- Used as the stimulus source feeding enum-method checkers and as a reference model for sparse enum walking.

Parameters:
- DW, 32, width of `cmd_val` and `out_value`; member values are zero-extended to DW.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  3  0 NEXT, 1 PREV, 2 FIRST, 3 LAST, 4 SEEK, 5-7 illegal
- cmd_cnt  input  4  step count for NEXT/PREV; 0 is treated as 1
- cmd_val  input  DW  target value for SEEK
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_value  output  DW  current member value
- out_index  output  4  current member ordinal, 0..14
- out_wrap  output  1  command crossed the last↔first boundary
- out_err  output  1  SEEK miss or illegal opcode

Behaviour:
- Enumeration is fixed: 15 members, ordinal index:value pairs:
  - 0:0 father, 1:1 mother, 2:2 son0, 3:3 son1, 4:4 daughter, 5:5 gerbil
  - 6:10 dog0, 7:11 dog1, 8:12 dog2
  - 9:20 cat3, 10:21 cat4, 11:22 cat5
  - 12:30 car3, 13:31 car2, 14:32 car1
- FSM states: IDLE, STEP, SCAN, EMIT. `cmd_ready` = (state==IDLE).
- Command is accepted on a clock edge where `cmd_valid && cmd_ready`; call that edge T.
- Reset values:
  - cursor index = 0; state = IDLE
  - `out_valid` = 0; `out_value` = 0, `out_index` = 0, `out_wrap` = 0, `out_err` = 0
  - `cmd_ready` = 1 in the first cycle after reset.
- NEXT/PREV:
  - STEP lasts n = max(`cmd_cnt`,1) cycles; the cursor moves one ordinal per edge, with modular wrap (14→0 on NEXT, 0→14 on PREV).
  - `out_wrap` = 1 if any single move wrapped.
  - `out_valid` rises at edge T+n.
- FIRST/LAST: cursor set to 0 / 14; `out_valid` at T+1; `out_wrap` = 0.
- SEEK:
  - SCAN compares ordinal k (0..14) against `cmd_val`, one member per cycle. `cmd_val` is captured at T.
  - Hit at ordinal k: cursor = k, `out_valid` at T+k+1.
  - Miss: `out_err` = 1, cursor unchanged, `out_valid` at T+15.
- Illegal opcode: `out_err` = 1, cursor unchanged, `out_valid` at T+1.
- EMIT:
  - `out_*` are held stable while `out_valid` && !`out_ready`.
  - Leaves to IDLE on `out_valid && out_ready`; `out_valid` drops on the same edge.
  - No new command is accepted until the next cycle, so back-to-back commands cost at least one IDLE cycle.
- The cursor persists across commands; `out_value`/`out_index` always reflect the cursor after the command.
- `rst` asserted in any state: aborts at the next edge, discards any pending result, restores reset values.
- `cmd_*` inputs are ignored outside IDLE.

Optional Feature:
- Macro: ENUM_STEPPER_NAME_EN.
- When defined:
  - Adds output `out_name`, 64 bits: the member name as ASCII, left-aligned, space-padded (e.g. "son0    ").
  - `out_name` is valid with `out_valid` and resets to "father  ".
  - On an error result, `out_name` carries the unchanged cursor's name.
- When undefined: port and name ROM are absent; all other behaviour is identical.

Test Plan:
- Reset, then FIRST → `out_valid` at T+1: value 0, index 0, wrap 0, err 0; `cmd_ready` low until the output is taken.
- From index 0, NEXT cnt=6 → `out_valid` exactly 6 edges after T: value 10, index 6, wrap 0. Then NEXT cnt=0 → value 11, index 7, at T+1.
- LAST → value 32, index 14; NEXT cnt=1 → value 0, index 0, wrap 1; PREV cnt=3 → value 30, index 12, wrap 1.
- SEEK 21 → value 21, index 10 at T+11. SEEK 7 → err 1, value/index unchanged (21/10), at T+15. Opcode 6 → err 1 at T+1.
- Hold `out_ready` low 5 cycles after `out_valid` → `out_*` stable, `cmd_ready` 0, cursor frozen; release → handshake completes and IDLE is reached next cycle.
- Assert `rst` mid-STEP of NEXT cnt=15 → next cycle `out_valid` 0, `cmd_ready` 1; FIRST returns value 0, and NEXT cnt=1 then returns value 1 (confirms cursor reset).

Source files
------------

// File: rtl/enum_stepper.sv
// Cursor over a fixed 15-member sparse enumeration: NEXT/PREV/FIRST/LAST/SEEK over valid/ready.
// Optional member-name output enabled by defining ENUM_STEPPER_NAME_EN.
module enum_stepper #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [3:0]    cmd_cnt,
    input  logic [DW-1:0] cmd_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_value,
    output logic [3:0]    out_index,
    output logic          out_wrap,
    output logic          out_err
`ifdef ENUM_STEPPER_NAME_EN
    ,
    output logic [63:0]   out_name
`endif
);

    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_PREV  = 3'd1;
    localparam logic [2:0] OP_FIRST = 3'd2;
    localparam logic [2:0] OP_LAST  = 3'd3;
    localparam logic [2:0] OP_SEEK  = 3'd4;
    localparam logic [3:0] IDX_LAST = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_SCAN = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    function automatic logic [5:0] member_value(input logic [3:0] idx);
        logic [5:0] v;
        case (idx)
            4'd0:    v = 6'd0;
            4'd1:    v = 6'd1;
            4'd2:    v = 6'd2;
            4'd3:    v = 6'd3;
            4'd4:    v = 6'd4;
            4'd5:    v = 6'd5;
            4'd6:    v = 6'd10;
            4'd7:    v = 6'd11;
            4'd8:    v = 6'd12;
            4'd9:    v = 6'd20;
            4'd10:   v = 6'd21;
            4'd11:   v = 6'd22;
            4'd12:   v = 6'd30;
            4'd13:   v = 6'd31;
            4'd14:   v = 6'd32;
            default: v = 6'd0;
        endcase
        return v;
    endfunction

`ifdef ENUM_STEPPER_NAME_EN
    function automatic logic [63:0] member_name(input logic [3:0] idx);
        logic [63:0] n;
        case (idx)
            4'd0:    n = "father  ";
            4'd1:    n = "mother  ";
            4'd2:    n = "son0    ";
            4'd3:    n = "son1    ";
            4'd4:    n = "daughter";
            4'd5:    n = "gerbil  ";
            4'd6:    n = "dog0    ";
            4'd7:    n = "dog1    ";
            4'd8:    n = "dog2    ";
            4'd9:    n = "cat3    ";
            4'd10:   n = "cat4    ";
            4'd11:   n = "cat5    ";
            4'd12:   n = "car3    ";
            4'd13:   n = "car2    ";
            4'd14:   n = "car1    ";
            default: n = "father  ";
        endcase
        return n;
    endfunction
`endif

    state_t          state_r, state_s;
    logic [3:0]      cursor_r, cursor_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [3:0]      scan_r, scan_s;
    logic [2:0]      op_r, op_s;
    logic [DW-1:0]   val_r, val_s;
    logic            wrap_r, wrap_s;
    logic            err_r, err_s;
    logic            hit_s;
    logic            cmd_ready_r;
    logic            out_valid_r, out_valid_s;
    logic [DW-1:0]   out_value_r, out_value_s;
    logic [3:0]      out_index_r, out_index_s;
    logic            out_wrap_r, out_wrap_s;
    logic            out_err_r, out_err_s;

    assign hit_s = (DW'(member_value(scan_r)) == val_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = (cmd_op == OP_SEEK) ? ST_SCAN : ST_STEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (cnt_r == 4'd1) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_STEP;
                end
            end
            ST_SCAN: begin
                if (hit_s || (scan_r == IDX_LAST)) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath and output next values; results are loaded on entry to EMIT
    always_comb begin
        cursor_s    = cursor_r;
        cnt_s       = cnt_r;
        scan_s      = scan_r;
        op_s        = op_r;
        val_s       = val_r;
        wrap_s      = wrap_r;
        err_s       = err_r;
        out_valid_s = out_valid_r;
        out_value_s = out_value_r;
        out_index_s = out_index_r;
        out_wrap_s  = out_wrap_r;
        out_err_s   = out_err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_s   = cmd_op;
                    val_s  = cmd_val;
                    scan_s = 4'd0;
                    wrap_s = 1'b0;
                    err_s  = 1'b0;
                    if ((cmd_op == OP_NEXT) || (cmd_op == OP_PREV)) begin
                        cnt_s = (cmd_cnt == 4'd0) ? 4'd1 : cmd_cnt;
                    end else begin
                        cnt_s = 4'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_STEP: begin
                cnt_s = cnt_r - 4'd1;
                case (op_r)
                    OP_NEXT: begin
                        cursor_s = (cursor_r == IDX_LAST) ? 4'd0 : cursor_r + 4'd1;
                        wrap_s   = wrap_r | (cursor_r == IDX_LAST);
                    end
                    OP_PREV: begin
                        cursor_s = (cursor_r == 4'd0) ? IDX_LAST : cursor_r - 4'd1;
                        wrap_s   = wrap_r | (cursor_r == 4'd0);
                    end
                    OP_FIRST: cursor_s = 4'd0;
                    OP_LAST:  cursor_s = IDX_LAST;
                    default:  err_s = 1'b1;
                endcase
            end
            ST_SCAN: begin
                scan_s = scan_r + 4'd1;
                if (hit_s) begin
                    cursor_s = scan_r;
                end else if (scan_r == IDX_LAST) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: out_valid_s = 1'b0;
        endcase
        if ((state_s == ST_EMIT) && (state_r != ST_EMIT)) begin
            out_valid_s = 1'b1;
            out_value_s = DW'(member_value(cursor_s));
            out_index_s = cursor_s;
            out_wrap_s  = wrap_s;
            out_err_s   = err_s;
        end else begin
            out_err_s   = out_err_r;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_r    <= 4'd0;
            cnt_r       <= 4'd0;
            scan_r      <= 4'd0;
            op_r        <= 3'd0;
            val_r       <= '0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            out_value_r <= '0;
            out_index_r <= 4'd0;
            out_wrap_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            cursor_r    <= cursor_s;
            cnt_r       <= cnt_s;
            scan_r      <= scan_s;
            op_r        <= op_s;
            val_r       <= val_s;
            wrap_r      <= wrap_s;
            err_r       <= err_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            out_valid_r <= out_valid_s;
            out_value_r <= out_value_s;
            out_index_r <= out_index_s;
            out_wrap_r  <= out_wrap_s;
            out_err_r   <= out_err_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign out_valid = out_valid_r;
    assign out_value = out_value_r;
    assign out_index = out_index_r;
    assign out_wrap  = out_wrap_r;
    assign out_err   = out_err_r;

`ifdef ENUM_STEPPER_NAME_EN
    assign out_name = member_name(out_index_r);
`endif

endmodule

// File: tb/tb_enum_stepper.sv
// Randomized self-checking bench for enum_stepper against a list-walking reference model.
module tb_enum_stepper;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [3:0]    cmd_cnt = 4'd0;
    logic [DW-1:0] cmd_val = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_value;
    logic [3:0]    out_index;
    logic          out_wrap;
    logic          out_err;
`ifdef ENUM_STEPPER_NAME_EN
    logic [63:0]   out_name;
`endif

    enum_stepper #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_val(cmd_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_index(out_index),
        .out_wrap(out_wrap), .out_err(out_err)
`ifdef ENUM_STEPPER_NAME_EN
        , .out_name(out_name)
`endif
    );

    always #5 clk = ~clk;

    int vals [15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 20, 21, 22, 30, 31, 32};
`ifdef ENUM_STEPPER_NAME_EN
    logic [63:0] names [15] = '{"father  ", "mother  ", "son0    ", "son1    ", "daughter",
                                "gerbil  ", "dog0    ", "dog1    ", "dog2    ", "cat3    ",
                                "cat4    ", "cat5    ", "car3    ", "car2    ", "car1    "};
`endif

    int n_chk = 0;
    int n_pass = 0;
    int model_cur = 0;
    int exp_value = 0;
    int exp_index = 0;
    int exp_wrap = 0;
    int exp_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every negedge with a result present: outputs must equal the model and input side is blocked
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            chk("mon_value", out_value, exp_value);
            chk("mon_index", out_index, exp_index);
            chk("mon_wrap", out_wrap, exp_wrap);
            chk("mon_err", out_err, exp_err);
            chk("mon_cmd_ready", cmd_ready, 0);
`ifdef ENUM_STEPPER_NAME_EN
            chk("mon_name", out_name, names[exp_index]);
`endif
        end
    end

    task automatic do_cmd(input int op, input int cnt, input int val, input int hold,
                          input int lv, input int li, input int lw, input int le, input int ll);
        int n, nc, wr, er, lat, cyc;
        n = (cnt == 0) ? 1 : cnt;
        nc = model_cur; wr = 0; er = 0; lat = 1;
        if (op == 0) begin
            nc = (model_cur + n) % 15; wr = (model_cur + n >= 15) ? 1 : 0; lat = n;
        end else if (op == 1) begin
            nc = (model_cur - n + 15) % 15; wr = (model_cur - n < 0) ? 1 : 0; lat = n;
        end else if (op == 2) begin
            nc = 0;
        end else if (op == 3) begin
            nc = 14;
        end else if (op == 4) begin
            er = 1; lat = 15;
            for (int k = 14; k >= 0; k--) begin
                if (vals[k] == val) begin
                    nc = k; er = 0; lat = k + 1;
                end
            end
        end else begin
            er = 1;
        end
        exp_value = vals[nc]; exp_index = nc; exp_wrap = wr; exp_err = er;

        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_cnt = cnt[3:0]; cmd_val = val;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_val = $urandom;
        cyc = 0;
        do begin
            @(posedge clk); #1 cyc++;
        end while (!out_valid && cyc < 40);
        chk("latency", cyc, lat);
        if (lv >= 0) begin
            chk("lit_value", out_value, lv);
            chk("lit_index", out_index, li);
            chk("lit_wrap", out_wrap, lw);
            chk("lit_err", out_err, le);
            chk("lit_latency", cyc, ll);
        end
        model_cur = nc;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk("handshake_drop", out_valid, 0);
        chk("handshake_idle", cmd_ready, 1);
    endtask

    initial begin
        int op, cnt, val;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_value", out_value, 0);
        chk("rst_index", out_index, 0);
        chk("rst_wrap", out_wrap, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        mon_en = 1'b1;

        do_cmd(2, 0, 0, 0,   0,  0, 0, 0, 1);
        do_cmd(0, 6, 0, 0,  10,  6, 0, 0, 6);
        do_cmd(0, 0, 0, 0,  11,  7, 0, 0, 1);
        do_cmd(3, 0, 0, 0,  32, 14, 0, 0, 1);
        do_cmd(0, 1, 0, 0,   0,  0, 1, 0, 1);
        do_cmd(1, 3, 0, 0,  30, 12, 1, 0, 3);
        do_cmd(4, 0, 21, 0, 21, 10, 0, 0, 11);
        do_cmd(4, 0, 7, 5,  21, 10, 0, 1, 15);
        do_cmd(6, 0, 0, 0,  21, 10, 0, 1, 1);
        do_cmd(4, 0, 0, 2,   0,  0, 0, 0, 1);
        do_cmd(4, 0, 32, 0, 32, 14, 0, 0, 15);

        // Abort a long NEXT with reset and confirm the cursor restarts at 0
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_cnt = 4'd15;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_index", out_index, 0);
        model_cur = 0;
        do_cmd(2, 0, 0, 0, 0, 0, 0, 0, 1);
        do_cmd(0, 1, 0, 0, 1, 1, 0, 0, 1);

        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
            cnt = $urandom_range(0, 15);
            val = ($urandom_range(0, 1) == 1) ? vals[$urandom_range(0, 14)] : $urandom_range(0, 40);
            do_cmd(op, cnt, val, $urandom_range(0, 3), -1, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
